axi_rd_arbiter: RTL

//  Shares one AXI4 read port (AR+R) between N_REQ requesters ahead of the 512-bit AXI4 register slice / memory path.

---
 rtl/axi_rd_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin N-to-1 AXI4 read (AR+R) arbiter with per-requester outstanding cap
// Optional statistics counters enabled by defining AXI_RD_ARB_STATS_EN.
module axi_rd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 512,
  parameter int ID_BITS   = 6,
  parameter int MAX_OUTS  = 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_REQ*ADDR_BITS-1:0] s_araddr,
  input  logic [N_REQ*8-1:0]         s_arlen,
  input  logic [N_REQ-1:0]           s_arvalid,
  output logic [N_REQ-1:0]           s_arready,
  output logic [DATA_BITS-1:0]       s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rlast,
  output logic [N_REQ-1:0]           s_rvalid,
  input  logic [N_REQ-1:0]           s_rready,
  output logic [ID_BITS-1:0]         m_arid,
  output logic [ADDR_BITS-1:0]       m_araddr,
  output logic [7:0]                 m_arlen,
  output logic [2:0]                 m_arsize,
  output logic [1:0]                 m_arburst,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [ID_BITS-1:0]         m_rid,
  input  logic [DATA_BITS-1:0]       m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast,
  input  logic                       m_rvalid,
  output logic                       m_rready
`ifdef AXI_RD_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]        stat_ar_cnt,
  output logic [31:0]                stat_rid_err
`endif
);

  localparam int IDX_BITS = $clog2(N_REQ);
  localparam int CW       = $clog2(MAX_OUTS + 1);
  localparam logic [CW-1:0]       MAX_C    = CW'(MAX_OUTS);
  localparam logic [IDX_BITS:0]   N_W      = (IDX_BITS + 1)'(N_REQ);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_REQ - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_q;
  logic                  m_arvalid_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [7:0]            len_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [IDX_BITS-1:0]   ptr_q;
  logic [CW-1:0]         outs_q [N_REQ];

  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      inc;
  logic [N_REQ-1:0]      dec;
  logic [IDX_BITS-1:0]   grant;
  logic                  any_elig;
  logic                  accept;
  logic [IDX_BITS-1:0]   rid_idx;
  logic                  rid_ok;
  logic                  r_done;
  int                    cand;

  assign m_arid    = ID_BITS'(idx_q);
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = 3'($clog2(DATA_BITS / 8));
  assign m_arburst = 2'b01;
  assign m_arvalid = m_arvalid_q;

  // Round-robin search for the first eligible requester starting at ptr_q
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    cand     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      elig[k] = s_arvalid[k] && (outs_q[k] < MAX_C);
    end
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        grant    = IDX_BITS'(cand);
      end
    end
  end

  // A new request is taken when the latch is free: idle, or current AR leaving this cycle
  assign accept = any_elig && !areset && (state_q == IDLE || m_arready);

  // One-cycle ready pulse to the winner plus per-requester increment strobe
  always_comb begin
    s_arready = '0;
    inc       = '0;
    if (accept) begin
      s_arready[grant] = 1'b1;
      inc[grant]       = 1'b1;
    end
  end

  // AR FSM: latch the winner, hold it on the master port until accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      m_arvalid_q <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
    end else begin
      case (state_q)
        IDLE, ISSUE: begin
          if (accept) begin
            state_q     <= ISSUE;
            m_arvalid_q <= 1'b1;
            addr_q      <= s_araddr[int'(grant)*ADDR_BITS +: ADDR_BITS];
            len_q       <= s_arlen[int'(grant)*8 +: 8];
            idx_q       <= grant;
            ptr_q       <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
          end else if (state_q == ISSUE && m_arready) begin
            state_q     <= IDLE;
            m_arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          m_arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // R path: pure routing by RID; illegal IDs are sunk so the master never stalls on them
  always_comb begin
    rid_idx  = m_rid[IDX_BITS-1:0];
    rid_ok   = ((m_rid >> IDX_BITS) == '0) && ({1'b0, rid_idx} < N_W);
    s_rdata  = m_rdata;
    s_rresp  = m_rresp;
    s_rlast  = m_rlast;
    m_rready = rid_ok ? s_rready[rid_idx] : 1'b1;
    r_done   = m_rvalid && m_rready && m_rlast && rid_ok;
    s_rvalid = '0;
    dec      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s_rvalid[k] = m_rvalid && rid_ok && (rid_idx == IDX_BITS'(k));
      // Stale completions (counter already 0) are ignored so the count cannot wrap
      dec[k]      = r_done && (rid_idx == IDX_BITS'(k)) && (outs_q[k] != '0);
    end
  end

  // Outstanding-burst counters: +1 per accepted AR, -1 per completed burst
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k < N_REQ; k++) outs_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (inc[k] && !dec[k]) begin
          outs_q[k] <= outs_q[k] + 1'b1;
        end else if (dec[k] && !inc[k]) begin
          outs_q[k] <= outs_q[k] - 1'b1;
        end
      end
    end
  end

`ifdef AXI_RD_ARB_STATS_EN
  logic [31:0] stat_ar_q [N_REQ];
  logic [31:0] stat_rid_err_q;

  // Free-running grant and illegal-RID counters, wrapping at 2^32
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k < N_REQ; k++) stat_ar_q[k] <= '0;
      stat_rid_err_q <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (inc[k]) stat_ar_q[k] <= stat_ar_q[k] + 32'd1;
      end
      if (m_rvalid && !rid_ok) stat_rid_err_q <= stat_rid_err_q + 32'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) stat_ar_cnt[k*32 +: 32] = stat_ar_q[k];
    stat_rid_err = stat_rid_err_q;
  end
`endif

endmodule
